// File: rtl/alu_pkg.sv
// Shared command codes and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_AND = 3'b010;
    localparam logic [2:0] CMD_OR  = 3'b011;
    localparam logic [2:0] CMD_XOR = 3'b100;
    localparam logic [2:0] CMD_SHL = 3'b101;
    localparam logic [2:0] CMD_SHR = 3'b110;
    localparam logic [2:0] CMD_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the single-cycle commands; MUL is handled by the
// sequential datapath in alu_seq and yields zero result here.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       com,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] ext;

    // For SUB the extra top bit of the widened difference is the borrow.
    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (com)
            CMD_ADD: begin
                ext    = {1'b0, op_a} + {1'b0, op_b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            CMD_SUB: begin
                ext    = {1'b0, op_a} - {1'b0, op_b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            CMD_AND: result = op_a & op_b;
            CMD_OR:  result = op_a | op_b;
            CMD_XOR: result = op_a ^ op_b;
            CMD_SHL: begin
                result = {op_a[WIDTH-2:0], 1'b0};
                carry  = op_a[WIDTH-1];
            end
            CMD_SHR: begin
                result = {1'b0, op_a[WIDTH-1:1]};
                carry  = op_a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered result and flags, accumulate mode, and an
// iterative shift-add multiplier behind a start/busy/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       com,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R_hi
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     rhi_q, rhi_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     core_res;
    logic                 core_carry;
    logic                 accept;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   prod_step;

    assign op_a      = acc_en ? r_q : A;
    assign accept    = (state_q == ST_IDLE) && start;
    assign last_iter = (cnt_q == LAST_ITER);
    // Multiplicand shifts left each step, so a single add per multiplier bit suffices.
    assign prod_step = prod_q + (mcand_q & {2*WIDTH{mplr_q[0]}});

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_a   (op_a),
        .op_b   (B),
        .com    (com),
        .result (core_res),
        .carry  (core_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && com == CMD_MUL) state_d = ST_MUL;
            ST_MUL:  if (last_iter)               state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_MUL);
    end

    always_comb begin
        r_d     = r_q;
        rhi_d   = rhi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (com == CMD_MUL) begin
                mcand_d = {{WIDTH{1'b0}}, op_a};
                mplr_d  = B;
                prod_d  = '0;
                cnt_d   = '0;
            end else begin
                r_d     = core_res;
                rhi_d   = '0;
                carry_d = core_carry;
                zero_d  = (core_res == '0);
                done_d  = 1'b1;
            end
        end else if (state_q == ST_MUL) begin
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            prod_d  = prod_step;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_iter) begin
                r_d     = prod_step[WIDTH-1:0];
                rhi_d   = prod_step[2*WIDTH-1:WIDTH];
                carry_d = |prod_step[2*WIDTH-1:WIDTH];
                zero_d  = (prod_step == '0);
                done_d  = 1'b1;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            rhi_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            r_q     <= r_d;
            rhi_q   <= rhi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done  = done_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign R     = r_q;
    assign R_hi  = rhi_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4 and WIDTH=8: stimulus pushes
// hand-computed results, monitors pop and compare on every done pulse.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] r;
        logic [7:0] rh;
        logic       c;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset4, start4, acc4;
    logic [2:0] com4;
    logic [3:0] a4, b4;
    logic       busy4, done4, carry4, zero4;
    logic [3:0] R4, Rhi4;

    logic       reset8, start8, acc8;
    logic [2:0] com8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8, zero8;
    logic [7:0] R8, Rhi8;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .com(com4), .acc_en(acc4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .carry(carry4),
        .zero(zero4), .R(R4), .R_hi(Rhi4)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .com(com8), .acc_en(acc8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .carry(carry8),
        .zero(zero8), .R(R8), .R_hi(Rhi8)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            checkOutput("dut4 busy with done", 16'(busy4), 16'd0);
            checkOutput("dut4 done has expected entry", 16'(q4.size() != 0), 16'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                checkOutput("dut4 R", 16'(R4), 16'(e4.r));
                checkOutput("dut4 R_hi", 16'(Rhi4), 16'(e4.rh));
                checkOutput("dut4 carry", 16'(carry4), 16'(e4.c));
                checkOutput("dut4 zero", 16'(zero4), 16'(e4.z));
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checkOutput("dut8 busy with done", 16'(busy8), 16'd0);
            checkOutput("dut8 done has expected entry", 16'(q8.size() != 0), 16'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                checkOutput("dut8 R", 16'(R8), 16'(e8.r));
                checkOutput("dut8 R_hi", 16'(Rhi8), 16'(e8.rh));
                checkOutput("dut8 carry", 16'(carry8), 16'(e8.c));
                checkOutput("dut8 zero", 16'(zero8), 16'(e8.z));
            end
        end
    end

    task automatic applyStimulus4(input logic [2:0] c, input logic acc, input logic [3:0] a,
                                  input logic [3:0] b, input logic push, input logic [3:0] er,
                                  input logic [3:0] erh, input logic ec, input logic ez);
        start4 = 1'b1;
        com4   = c;
        acc4   = acc;
        a4     = a;
        b4     = b;
        if (push) q4.push_back('{r: {4'b0, er}, rh: {4'b0, erh}, c: ec, z: ez});
        @(negedge clk);
    endtask

    task automatic applyStimulus8(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] er, input logic [7:0] erh,
                                  input logic ec, input logic ez);
        start8 = 1'b1;
        com8   = c;
        acc8   = 1'b0;
        a8     = a;
        b8     = b;
        q8.push_back('{r: er, rh: erh, c: ec, z: ez});
        @(negedge clk);
    endtask

    task automatic idle4(input int n);
        start4 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle8(input int n);
        start8 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mulBusy4();
        start4 = 1'b0;
        checkOutput("dut4 busy after accept", 16'(busy4), 16'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("dut4 busy during mul", 16'(busy4), 16'd1);
        end
        @(negedge clk);
        checkOutput("dut4 busy after mul", 16'(busy4), 16'd0);
        checkOutput("dut4 done after mul", 16'(done4), 16'd1);
    endtask

    task automatic mulBusy8();
        start8 = 1'b0;
        checkOutput("dut8 busy after accept", 16'(busy8), 16'd1);
        repeat (7) begin
            @(negedge clk);
            checkOutput("dut8 busy during mul", 16'(busy8), 16'd1);
        end
        @(negedge clk);
        checkOutput("dut8 busy after mul", 16'(busy8), 16'd0);
        checkOutput("dut8 done after mul", 16'(done8), 16'd1);
    endtask

    initial begin
        reset4 = 1'b1; start4 = 1'b0; acc4 = 1'b0; com4 = '0; a4 = '0; b4 = '0;
        reset8 = 1'b1; start8 = 1'b0; acc8 = 1'b0; com8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        checkOutput("dut4 reset R", 16'(R4), 16'd0);
        checkOutput("dut4 reset R_hi", 16'(Rhi4), 16'd0);
        checkOutput("dut4 reset carry", 16'(carry4), 16'd0);
        checkOutput("dut4 reset zero", 16'(zero4), 16'd0);
        checkOutput("dut4 reset busy", 16'(busy4), 16'd0);
        checkOutput("dut4 reset done", 16'(done4), 16'd0);
        checkOutput("dut8 reset R", 16'(R8), 16'd0);
        checkOutput("dut8 reset busy", 16'(busy8), 16'd0);
        reset4 = 1'b0;
        reset8 = 1'b0;
        @(negedge clk);

        // 0111 + 1001 wraps to zero with carry out
        applyStimulus4(CMD_ADD, 1'b0, 4'b0111, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1);
        idle4(1);
        checkOutput("dut4 done one cycle", 16'(done4), 16'd0);
        checkOutput("dut4 busy single op", 16'(busy4), 16'd0);

        applyStimulus4(CMD_SUB, 1'b0, 4'b0010, 4'b0101, 1'b1, 4'b1101, 4'b0000, 1'b1, 1'b0);
        idle4(1);

        // Back-to-back single-cycle commands
        applyStimulus4(CMD_AND, 1'b0, 4'b1100, 4'b1010, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0);
        applyStimulus4(CMD_OR,  1'b0, 4'b1100, 4'b1010, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
        applyStimulus4(CMD_XOR, 1'b0, 4'b1100, 4'b1010, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0);
        applyStimulus4(CMD_SHR, 1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0);
        applyStimulus4(CMD_SHL, 1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0);
        applyStimulus4(CMD_SUB, 1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        idle4(1);

        // 15 * 15 = 225 = 1110_0001
        applyStimulus4(CMD_MUL, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0);
        mulBusy4();
        idle4(1);

        // Reset two edges into a MUL: nothing may complete afterwards
        applyStimulus4(CMD_MUL, 1'b0, 4'b0101, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        reset4 = 1'b1;
        @(negedge clk);
        checkOutput("dut4 midmul reset R", 16'(R4), 16'd0);
        checkOutput("dut4 midmul reset R_hi", 16'(Rhi4), 16'd0);
        checkOutput("dut4 midmul reset carry", 16'(carry4), 16'd0);
        checkOutput("dut4 midmul reset zero", 16'(zero4), 16'd0);
        checkOutput("dut4 midmul reset busy", 16'(busy4), 16'd0);
        checkOutput("dut4 midmul reset done", 16'(done4), 16'd0);
        reset4 = 1'b0;
        idle4(6);
        applyStimulus4(CMD_ADD, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0);
        idle4(1);

        // Accumulate chain: 3, then 3+4 with port A ignored, then shift left
        applyStimulus4(CMD_ADD, 1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0);
        applyStimulus4(CMD_ADD, 1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0111, 4'b0000, 1'b0, 1'b0);
        applyStimulus4(CMD_SHL, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
        idle4(1);

        // Starts raised while the multiply is running must be ignored
        applyStimulus4(CMD_MUL, 1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; com4 = CMD_ADD; a4 = 4'b0001; b4 = 4'b0001;
        repeat (2) @(negedge clk);
        idle4(4);

        applyStimulus4(CMD_MUL, 1'b0, 4'b0000, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        idle4(6);

        applyStimulus8(CMD_ADD, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1);
        idle8(1);
        applyStimulus8(CMD_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0);
        mulBusy8();
        idle8(3);

        checkOutput("dut4 scoreboard drained", 16'(q4.size()), 16'd0);
        checkOutput("dut8 scoreboard drained", 16'(q8.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
